// File: rtl/sha256_mem_arbiter.sv
// Round-robin ownership arbiter for a single shared memory port among NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to add a MAX_HOLD grant limit with forced revoke and requester masking.
module sha256_mem_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      gnt,
    input  logic [NUM_REQ*16-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]      req_we,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [31:0]             req_rdata,
    output logic                    memory_clk,
    output logic [15:0]             memory_addr,
    output logic                    enable_write,
    output logic [31:0]             memory_write_data,
    input  logic [31:0]             memory_read_data,
    output logic [2:0]              owner,
    output logic                    busy,
    output logic                    timeout
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned OW = 3;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2) begin : g_bad_param
        $error("sha256_mem_arbiter: NUM_REQ must be 2..8 and MAX_HOLD at least 2");
    end

    logic [1:0]         state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [OW-1:0]      owner_nxt;
    logic               busy_nxt;
    logic [OW-1:0]      rr_ptr, rr_nxt;
    logic [NUM_REQ-1:0] eligible;
    logic [OW-1:0]      winner;
    logic               own_req;
    logic [AW-1:0]      own_addr;
    logic               own_we;
    logic [DW-1:0]      own_wdata;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD);
    logic [HW-1:0]      hold_cnt, hold_nxt;
    logic [NUM_REQ-1:0] mask, mask_nxt;
    logic               timeout_nxt;
    assign eligible = req & ~mask;
`else
    assign eligible = req;
    assign timeout  = 1'b0;
`endif

    assign memory_clk = clk;
    assign req_rdata  = memory_read_data;

    // Round-robin pick: first eligible at or above rr_ptr, else first eligible overall
    always_comb begin
        logic hi_found, lo_found;
        logic [OW-1:0] hi_idx, lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eligible[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = OW'(i);
            end
            if (eligible[i] && !hi_found && (OW'(i) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = OW'(i);
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    // Owner's slice of the request bus
    always_comb begin
        own_req   = 1'b0;
        own_addr  = '0;
        own_we    = 1'b0;
        own_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == OW'(i)) begin
                own_req   = req[i];
                own_addr  = req_addr[AW*i +: AW];
                own_we    = req_we[i];
                own_wdata = req_wdata[DW*i +: DW];
            end
        end
    end

    // Only the current grantee ever drives the memory port
    assign memory_addr       = (state == GRANT) ? own_addr  : '0;
    assign enable_write      = (state == GRANT) ? own_we    : 1'b0;
    assign memory_write_data = (state == GRANT) ? own_wdata : '0;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        busy_nxt  = busy;
        rr_nxt    = rr_ptr;
`ifdef ARB_TIMEOUT_EN
        hold_nxt    = hold_cnt;
        mask_nxt    = mask & req;
        timeout_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt = GRANT;
                    gnt_nxt   = NUM_REQ'(1) << winner;
                    owner_nxt = winner;
                    busy_nxt  = 1'b1;
                    rr_nxt    = (32'(winner) == NUM_REQ - 1) ? '0 : winner + OW'(1);
`ifdef ARB_TIMEOUT_EN
                    hold_nxt  = '0;
`endif
                end
            end
            GRANT: begin
                if (!own_req) begin
                    state_nxt = RELEASE;
                    gnt_nxt   = '0;
                    owner_nxt = '0;
                    busy_nxt  = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                    state_nxt   = RELEASE;
                    gnt_nxt     = '0;
                    owner_nxt   = '0;
                    busy_nxt    = 1'b0;
                    timeout_nxt = 1'b1;
                    mask_nxt    = mask_nxt | (NUM_REQ'(1) << owner);
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
`endif
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                owner_nxt = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            owner  <= '0;
            busy   <= 1'b0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            owner  <= owner_nxt;
            busy   <= busy_nxt;
            rr_ptr <= rr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            mask     <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_nxt;
            mask     <= mask_nxt;
            timeout  <= timeout_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Directed bench for sha256_mem_arbiter: grant/release timing, round-robin order,
// non-owner isolation, async reset and the grant-hold limit (when ARB_TIMEOUT_EN is defined).
module tb_sha256_mem_arbiter;
    localparam int unsigned N = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [N*16-1:0] req_addr;
    logic [N-1:0]    req_we;
    logic [N*32-1:0] req_wdata;
    logic [31:0]     req_rdata;
    logic            memory_clk;
    logic [15:0]     memory_addr;
    logic            enable_write;
    logic [31:0]     memory_write_data;
    logic [31:0]     memory_read_data;
    logic [2:0]      owner;
    logic            busy;
    logic            timeout;

    int vectors    = 0;
    int miscompares = 0;

    sha256_mem_arbiter #(.NUM_REQ(N), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .req_rdata(req_rdata), .memory_clk(memory_clk), .memory_addr(memory_addr),
        .enable_write(enable_write), .memory_write_data(memory_write_data),
        .memory_read_data(memory_read_data), .owner(owner), .busy(busy), .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_owner", 64'(owner), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        req_addr = '0;
        req_we = '0;
        req_wdata = '0;
        memory_read_data = 32'h0;
        step(2);

        // Reset state
        chk("reset_gnt", 64'(gnt), 64'h0);
        chk("reset_owner", 64'(owner), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_timeout", 64'(timeout), 64'h0);
        chk("reset_addr", 64'(memory_addr), 64'h0);
        chk("reset_we", 64'(enable_write), 64'h0);
        chk("reset_wdata", 64'(memory_write_data), 64'h0);
        rst_n = 1'b1;
        step(1);

        // Single requester: grant one edge later, data path follows owner
        req_addr[15:0] = 16'h1234;
        req_we[0] = 1'b1;
        req_wdata[31:0] = 32'hDEADBEEF;
        memory_read_data = 32'h5A5AA5A5;
        req = 4'b0001;
        #1;
        chk("idle_addr_zero", 64'(memory_addr), 64'h0);
        chk("idle_we_zero", 64'(enable_write), 64'h0);
        chk("rdata_bcast", 64'(req_rdata), 64'h5A5AA5A5);
        step(1);
        chk("g0_gnt", 64'(gnt), 64'h1);
        chk("g0_owner", 64'(owner), 64'h0);
        chk("g0_busy", 64'(busy), 64'h1);
        chk("g0_addr", 64'(memory_addr), 64'h1234);
        chk("g0_we", 64'(enable_write), 64'h1);
        chk("g0_wdata", 64'(memory_write_data), 64'hDEADBEEF);
        req_addr[15:0] = 16'hABCD;
        #1;
        chk("g0_addr_track", 64'(memory_addr), 64'hABCD);
        step(38);
        chk("g0_hold", 64'(gnt), 64'h1);
        req = 4'b0000;
        #1;
        chk("g0_before_edge", 64'(gnt), 64'h1);
        step(1);
        chk("rel_gnt", 64'(gnt), 64'h0);
        chk("rel_busy", 64'(busy), 64'h0);
        chk("rel_addr", 64'(memory_addr), 64'h0);
        chk("rel_we", 64'(enable_write), 64'h0);
        step(1);
        chk("idle_gnt", 64'(gnt), 64'h0);

        // Round-robin order 0,1,2,3,0 with two-cycle gaps
        do_reset();
        req = 4'b1111;
        step(1);
        chk("rr_first", 64'(gnt), 64'h1);
        for (int k = 0; k < 4; k++) begin
            step(9);
            chk("rr_hold", 64'(gnt), 64'(1) << k);
            req[k] = 1'b0;
            step(1);
            chk("rr_gap1", 64'(gnt), 64'h0);
            req[k] = 1'b1;
            step(1);
            chk("rr_gap2", 64'(gnt), 64'h0);
            step(1);
            chk("rr_next_gnt", 64'(gnt), 64'(1) << ((k + 1) % 4));
            chk("rr_next_owner", 64'(owner), 64'((k + 1) % 4));
        end

        // Non-owner write isolation while requester 2 holds
        do_reset();
        req = 4'b0000;
        req_we = '0;
        req_addr[47:32] = 16'h2222;
        req_wdata[95:64] = 32'h22223333;
        req = 4'b0100;
        step(1);
        chk("iso_owner", 64'(owner), 64'h2);
        req[1] = 1'b1;
        req_we[1] = 1'b1;
        req_addr[31:16] = 16'h0055;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("iso_we", 64'(enable_write), 64'h0);
            chk("iso_addr", 64'(memory_addr), 64'h2222);
        end
        req_we[2] = 1'b1;
        #1;
        chk("iso_owner_we", 64'(enable_write), 64'h1);
        chk("iso_wdata", 64'(memory_write_data), 64'h22223333);
        // Requester 1 gives up while 2 still owns: its request is lost
        req[1] = 1'b0;
        step(1);
        req[2] = 1'b0;
        step(3);
        chk("lost_req_gnt", 64'(gnt), 64'h0);

        // Async reset in the middle of a grant
        req = 4'b0100;
        step(1);
        chk("mid_gnt", 64'(gnt), 64'h4);
        #3 rst_n = 1'b0;
        #1;
        chk("async_gnt", 64'(gnt), 64'h0);
        chk("async_owner", 64'(owner), 64'h0);
        chk("async_busy", 64'(busy), 64'h0);
        chk("async_addr", 64'(memory_addr), 64'h0);
        chk("async_we", 64'(enable_write), 64'h0);
        chk("async_wdata", 64'(memory_write_data), 64'h0);
        req = 4'b0010;
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_gnt", 64'(gnt), 64'h2);
        chk("post_rst_owner", 64'(owner), 64'h1);
        req = 4'b0000;
        req_we = '0;
        step(2);

`ifdef ARB_TIMEOUT_EN
        // Hold limit 8: forced revoke, timeout pulse, stuck requester masked
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("to_hold_gnt", 64'(gnt), 64'h1);
            chk("to_hold_pulse", 64'(timeout), 64'h0);
        end
        step(1);
        chk("to_revoke_gnt", 64'(gnt), 64'h0);
        chk("to_pulse", 64'(timeout), 64'h1);
        step(1);
        chk("to_pulse_end", 64'(timeout), 64'h0);
        step(1);
        chk("to_next_gnt", 64'(gnt), 64'h2);
        req[1] = 1'b0;
        step(3);
        chk("to_masked", 64'(gnt), 64'h0);
        req[0] = 1'b0;
        step(1);
        req[0] = 1'b1;
        step(1);
        chk("to_unmasked", 64'(gnt), 64'h1);
        req = 4'b0000;
        step(2);
`else
        // Unbounded grant without the hold limit
        do_reset();
        req = 4'b0001;
        step(1);
        for (int k = 0; k < 5000; k++) begin
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                chk("long_hold_gnt", 64'(gnt), 64'h1);
                chk("long_hold_timeout", 64'(timeout), 64'h0);
                break;
            end
            step(1);
        end
        chk("long_hold_end_gnt", 64'(gnt), 64'h1);
        chk("long_hold_end_timeout", 64'(timeout), 64'h0);
        req = 4'b0000;
        step(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sha256_mem_arbiter.md
SHA256_MEM_ARBITER -- requirements
Module: sha256_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-002 SHALL have parameter MAX_HOLD, default 1024, grant-hold cycle limit; used only under ARB_TIMEOUT_EN.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  in  1  sole clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req  in  NUM_REQ  per-requester memory ownership request, held high for the whole job.
REQ-007 SHALL have port gnt  out  NUM_REQ  one-hot-or-zero ownership grant.
REQ-008 SHALL have port req_addr  in  NUM_REQ*16  flattened per-requester address; slice i = bits 16i+15:16i.
REQ-009 SHALL have port req_we  in  NUM_REQ  per-requester write enable.
REQ-010 SHALL have port req_wdata  in  NUM_REQ*32  flattened per-requester write data.
REQ-011 SHALL have port req_rdata  out  32  memory read data broadcast to all requesters.
REQ-012 SHALL have ports memory_clk out 1, memory_addr out 16, enable_write out 1, memory_write_data out 32, memory_read_data in 32: shared memory port.
REQ-013 SHALL have port owner  out  3  index of current grantee; 0 when no grant.
REQ-014 SHALL have port busy  out  1  high while any gnt bit is high.
REQ-015 SHALL have port timeout  out  1  one-cycle pulse on forced revoke.

Function
REQ-016 SHALL implement states IDLE, GRANT, RELEASE.
REQ-017 IDLE: if any eligible req bit is high at a rising edge, SHALL select a winner, set gnt[winner]=1, owner=winner, go to GRANT on that edge; otherwise stay IDLE.
REQ-018 Winner SHALL be round-robin: search starts at (last owner + 1) mod NUM_REQ; after reset, search starts at 0.
REQ-019 GRANT: while req[owner]=1, SHALL hold gnt and owner unchanged regardless of other requests.
REQ-020 GRANT: when req[owner]=0 at an edge, SHALL clear gnt on that edge and go to RELEASE.
REQ-021 RELEASE SHALL last exactly one cycle with gnt=0, then go to IDLE; minimum gap between grants is 2 cycles.
REQ-022 In GRANT, memory_addr, enable_write and memory_write_data SHALL be combinational copies of the owner's req_addr, req_we and req_wdata slices.
REQ-023 In IDLE and RELEASE, memory_addr, enable_write and memory_write_data SHALL be 0.
REQ-024 memory_clk SHALL equal clk; req_rdata SHALL equal memory_read_data combinationally.
REQ-025 req_we from a non-owner SHALL never reach enable_write.
REQ-026 A req that rises and falls while another requester owns the bus SHALL be lost, with no queuing.
REQ-027 Simultaneous owner release and new request: release takes precedence; new grant no earlier than the edge after RELEASE.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, gnt=0, owner=0, busy=0, timeout=0, RR pointer=0, enable_write=0, memory_addr=0, memory_write_data=0.
REQ-029 Reset asserted mid-GRANT SHALL drop the grant immediately; after reset release the first grant follows REQ-017.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN defined: a hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-031 Under ARB_TIMEOUT_EN, when the counter reaches MAX_HOLD-1, the next edge SHALL clear gnt, pulse timeout for 1 cycle, enter RELEASE, and mask the revoked requester until its req goes low.
REQ-032 Macro ARB_TIMEOUT_EN undefined: no counter and no mask SHALL exist; timeout SHALL be tied 0; grants SHALL be unbounded.

Verification
REQ-033 req=4'b0001, held 40 cycles -> gnt=0001 one cycle later; memory_addr tracks req_addr[15:0]; gnt drops 1 cycle after req falls; RELEASE 1 cycle.
REQ-034 req=4'b1111 held constant, each owner drops req after 10 cycles then re-raises -> grant order 0,1,2,3,0; grant gaps of 2 cycles.
REQ-035 Owner 2 holds, requester 1 drives req_we=1 with addr 16'h0055 -> enable_write stays at owner 2's req_we; addr 16'h0055 never appears on memory_addr.
REQ-036 rst_n pulled low mid-GRANT on any cycle -> all outputs 0 asynchronously; after release, req=0010 -> gnt=0010.
REQ-037 ARB_TIMEOUT_EN, MAX_HOLD=8, req[0] stuck high, req[1] high -> gnt[0] lasts 8 cycles; timeout pulses; gnt[1] follows; req[0] ignored until it drops.
REQ-038 Without ARB_TIMEOUT_EN, req[0] held 5000 cycles -> gnt[0] held throughout; timeout stays 0.
